// File: rtl/demux_rr_sched_if.sv
// Handshake and demux bundle between producer, scheduler and consumers.
// The scheduler side is the slave modport; the stimulus side is the master.
interface demux_rr_sched_if #(
    parameter int DATA_W = 1
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [3:0]        ch_en;
    logic [3:0]        ch_ready;
    logic [1:0]        sel;
    logic [3:0]        y_valid;
    logic [DATA_W-1:0] y_data;
    logic              busy;
    logic [7:0]        beat_cnt;

    modport slave (
        input  in_valid, in_data, ch_en, ch_ready,
        output in_ready, sel, y_valid, y_data, busy, beat_cnt
    );

    modport master (
        output in_valid, in_data, ch_en, ch_ready,
        input  in_ready, sel, y_valid, y_data, busy, beat_cnt
    );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin burst scheduler steering one input stream into a 1:4 demux.
// One channel is granted for BURST beats; disabled or stalled channels are skipped.
module demux_rr_sched #(
    parameter int DATA_W = 1,
    parameter int BURST  = 4
) (
    input logic clk,
    input logic rst_n,
    demux_rr_sched_if.slave bus
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] elig;
    logic [1:0] pick;
    logic       found;
    logic       beat;
    logic       last;

    assign elig = bus.ch_en & bus.ch_ready;

    // First eligible channel at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] idx;
            idx = ptr + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign bus.in_ready = (state == XFER) && elig[bus.sel];
    assign beat = bus.in_valid && bus.in_ready;
    assign last = (bus.beat_cnt == 8'(BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= 2'd0;
            bus.sel      <= 2'd0;
            bus.y_valid  <= 4'd0;
            bus.y_data   <= '0;
            bus.busy     <= 1'b0;
            bus.beat_cnt <= 8'd0;
        end else begin
            bus.y_valid <= 4'd0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && found) begin
                        bus.sel      <= pick;
                        bus.beat_cnt <= 8'd0;
                        bus.busy     <= 1'b1;
                        state        <= XFER;
                    end
                end
                XFER: begin
                    if (!bus.ch_en[bus.sel]) begin
                        // Abort: the partial burst is dropped, not resumed.
                        ptr          <= bus.sel + 2'd1;
                        bus.beat_cnt <= 8'd0;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end else if (beat) begin
                        bus.y_valid <= 4'b0001 << bus.sel;
                        bus.y_data  <= bus.in_data;
                        if (last) begin
                            ptr          <= bus.sel + 2'd1;
                            bus.beat_cnt <= 8'd0;
                            bus.busy     <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            bus.beat_cnt <= bus.beat_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched with BURST=4, DATA_W=1.
// Outputs are sampled 1 time unit after the rising edge.
module tb_demux_rr_sched;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    demux_rr_sched_if #(.DATA_W(1)) bus ();

    demux_rr_sched #(.DATA_W(1), .BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
        bus.ch_en    = 4'h0;
        bus.ch_ready = 4'h0;
        tick();
        tick();
        vectors++;
        if ({bus.sel, bus.y_valid, bus.y_data, bus.busy, bus.in_ready, bus.beat_cnt}
            !== 17'd0) begin
            miscompares++;
            $display("FAIL reset sel=%0d yv=%b yd=%b busy=%b rdy=%b cnt=%0d want all 0",
                     bus.sel, bus.y_valid, bus.y_data, bus.busy, bus.in_ready,
                     bus.beat_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_channels();
        logic [3:0] pat;
        int k;
        pat = 4'b1101;
        k = 0;
        bus.ch_en    = 4'hF;
        bus.ch_ready = 4'hF;
        bus.in_valid = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            vectors++;
            if (bus.sel !== 2'(g % 4) || bus.busy !== 1'b1 || bus.y_valid !== 4'd0) begin
                miscompares++;
                $display("FAIL all_grant g=%0d sel=%0d busy=%b yv=%b want sel=%0d busy=1 yv=0",
                         g, bus.sel, bus.busy, bus.y_valid, g % 4);
            end
            for (int b = 0; b < 4; b++) begin
                bus.in_data = pat[k % 4];
                tick();
                vectors++;
                if (bus.y_valid !== (4'b0001 << (g % 4)) || bus.y_data !== pat[k % 4] ||
                    bus.beat_cnt !== ((b == 3) ? 8'd0 : 8'(b + 1)) ||
                    bus.busy !== (b != 3)) begin
                    miscompares++;
                    $display("FAIL all_beat g=%0d b=%0d yv=%b yd=%b cnt=%0d busy=%b want yv=%b yd=%b",
                             g, b, bus.y_valid, bus.y_data, bus.beat_cnt, bus.busy,
                             4'b0001 << (g % 4), pat[k % 4]);
                end
                k++;
            end
        end
    endtask

    task automatic test_masked();
        logic [1:0] exp_sel [4];
        exp_sel = '{2'd1, 2'd3, 2'd1, 2'd3};
        bus.ch_en = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            tick();
            vectors++;
            if (bus.sel !== exp_sel[g] || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL masked_grant g=%0d sel=%0d busy=%b want sel=%0d",
                         g, bus.sel, bus.busy, exp_sel[g]);
            end
            for (int b = 0; b < 4; b++) begin
                bus.in_data = 1'(b);
                tick();
                vectors++;
                if (bus.y_valid !== (4'b0001 << exp_sel[g]) || bus.y_data !== 1'(b)) begin
                    miscompares++;
                    $display("FAIL masked_beat g=%0d b=%0d yv=%b yd=%b want yv=%b",
                             g, b, bus.y_valid, bus.y_data, 4'b0001 << exp_sel[g]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bus.ch_en    = 4'b0100;
        bus.ch_ready = 4'hF;
        tick();
        vectors++;
        if (bus.sel !== 2'd2 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_grant sel=%0d busy=%b want sel=2 busy=1", bus.sel, bus.busy);
        end
        bus.ch_en = 4'b1100;
        for (int b = 0; b < 2; b++) begin
            tick();
            vectors++;
            if (bus.y_valid !== 4'b0100 || bus.beat_cnt !== 8'(b + 1)) begin
                miscompares++;
                $display("FAIL stall_pre b=%0d yv=%b cnt=%0d want yv=0100 cnt=%0d",
                         b, bus.y_valid, bus.beat_cnt, b + 1);
            end
        end
        bus.ch_ready = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_rdy c=%0d in_ready=%b want 0", c, bus.in_ready);
            end
            tick();
            vectors++;
            if (bus.y_valid !== 4'd0 || bus.beat_cnt !== 8'd2 || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold c=%0d yv=%b cnt=%0d busy=%b want yv=0 cnt=2 busy=1",
                         c, bus.y_valid, bus.beat_cnt, bus.busy);
            end
        end
        bus.ch_ready = 4'hF;
        for (int b = 0; b < 2; b++) begin
            tick();
            vectors++;
            if (bus.y_valid !== 4'b0100 || bus.beat_cnt !== ((b == 1) ? 8'd0 : 8'd3)) begin
                miscompares++;
                $display("FAIL stall_post b=%0d yv=%b cnt=%0d want yv=0100",
                         b, bus.y_valid, bus.beat_cnt);
            end
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle busy=%b want 0", bus.busy);
        end
        tick();
        vectors++;
        if (bus.sel !== 2'd3 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_next sel=%0d busy=%b want sel=3 busy=1", bus.sel, bus.busy);
        end
        bus.ch_en = 4'h0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.y_valid !== 4'd0) begin
            miscompares++;
            $display("FAIL stall_drain busy=%b yv=%b want 0", bus.busy, bus.y_valid);
        end
    endtask

    task automatic test_abort();
        bus.ch_en = 4'b0010;
        tick();
        vectors++;
        if (bus.sel !== 2'd1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_grant sel=%0d busy=%b want sel=1 busy=1", bus.sel, bus.busy);
        end
        bus.ch_en = 4'b0110;
        tick();
        vectors++;
        if (bus.y_valid !== 4'b0010 || bus.beat_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL abort_beat yv=%b cnt=%0d want yv=0010 cnt=1", bus.y_valid, bus.beat_cnt);
        end
        bus.ch_en = 4'b0100;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_rdy in_ready=%b want 0", bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.beat_cnt !== 8'd0 || bus.y_valid !== 4'd0) begin
            miscompares++;
            $display("FAIL abort_idle busy=%b cnt=%0d yv=%b want 0 0 0",
                     bus.busy, bus.beat_cnt, bus.y_valid);
        end
        bus.ch_en = 4'b0110;
        tick();
        vectors++;
        if (bus.sel !== 2'd2 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_next sel=%0d busy=%b want sel=2 busy=1", bus.sel, bus.busy);
        end
        bus.ch_en = 4'h0;
        tick();
    endtask

    task automatic test_idle_wait();
        bus.in_valid = 1'b0;
        bus.ch_en    = 4'hF;
        bus.ch_ready = 4'hF;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (bus.busy !== 1'b0 || bus.y_valid !== 4'd0 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL idle c=%0d busy=%b yv=%b rdy=%b want 0",
                         c, bus.busy, bus.y_valid, bus.in_ready);
            end
        end
        bus.in_valid = 1'b1;
        tick();
        vectors++;
        if (bus.busy !== 1'b1 || bus.sel !== 2'd3) begin
            miscompares++;
            $display("FAIL idle_grant busy=%b sel=%0d want busy=1 sel=3", bus.busy, bus.sel);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int b = 0; b < 3; b++) begin
            tick();
        end
        vectors++;
        if (bus.y_valid !== 4'b1000 || bus.beat_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL mid_beat3 yv=%b cnt=%0d want yv=1000 cnt=3", bus.y_valid, bus.beat_cnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.y_valid !== 4'd0 || bus.busy !== 1'b0 || bus.sel !== 2'd0 ||
            bus.beat_cnt !== 8'd0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset yv=%b busy=%b sel=%0d cnt=%0d rdy=%b want all 0",
                     bus.y_valid, bus.busy, bus.sel, bus.beat_cnt, bus.in_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.sel !== 2'd0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_regrant sel=%0d busy=%b want sel=0 busy=1", bus.sel, bus.busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_all_channels();
        test_masked();
        test_stall();
        test_abort();
        test_idle_wait();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
- Round-robin scheduler that shares one input stream between the four outputs of a 1:4 demux.
- Grants one output channel at a time for a burst of BURST beats, then drives the demux select and a one-hot output valid.
- Skips channels that are disabled or not ready.
- Sits between a single upstream producer and four downstream consumers.

Parameters:
DATA_W, 1, width of the data routed through the demux
BURST, 4, beats per grant (legal range 1..255)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat available
in_data  input  DATA_W  upstream data
in_ready  output  1  scheduler accepts beat this cycle
ch_en  input  4  per-channel enable mask
ch_ready  input  4  per-channel consumer ready
sel  output  2  demux select, registered, index of granted channel
y_valid  output  4  one-hot registered beat strobe per channel
y_data  output  DATA_W  registered data presented to all demux outputs
busy  output  1  high while in XFER
beat_cnt  output  8  beats accepted in current grant

Behaviour:
- Reset (async, rst_n=0): state IDLE, sel=0, rr pointer ptr=0, y_valid=0, y_data=0, beat_cnt=0, busy=0, in_ready=0.
- Eligible channel k: ch_en[k] & ch_ready[k].
- State IDLE:
  - in_ready=0.
  - If in_valid=1 and any channel is eligible: search ptr, ptr+1, ptr+2, ptr+3 (mod 4) and pick the first eligible channel.
  - Register sel=chosen, beat_cnt=0, go XFER.
  - Otherwise stay in IDLE; sel holds its last value.
- State XFER:
  - busy=1.
  - in_ready = ch_en[sel] & ch_ready[sel] (combinational).
  - Beat = in_valid & in_ready.
  - On a beat: next cycle y_valid[sel]=1 and y_data=in_data (1-cycle latency); beat_cnt increments.
  - No beat: y_valid=0 next cycle.
  - y_data holds its value between beats.
  - ch_ready[sel]=0: stall, stay in XFER, no timeout.
  - Beat with beat_cnt==BURST-1: ptr=sel+1 (mod 4), beat_cnt=0, go IDLE.
  - ch_en[sel]=0 while in XFER: abort. No beat that cycle, ptr=sel+1, beat_cnt=0, go IDLE. The partial burst is not resumed.
  - Upstream drops in_valid mid-burst: stay in XFER, keep the grant.
- General rules:
  - At most one y_valid bit is set in any cycle.
  - sel changes only on the IDLE→XFER transition.
  - Minimum grant-to-grant gap is one IDLE cycle.
  - BURST=1 returns to IDLE after every beat.
  - A single eligible channel is re-granted after its IDLE cycle (ptr wraps through the search).
  - ch_ready/ch_en changes on non-granted channels have no effect during XFER.
  - Reset asserted mid-burst: immediate return to reset values; the in-flight y_valid is cleared.

Test Plan:
1. Reset then all ch_en=4'hF, ch_ready=4'hF, in_valid=1, data 1,0,1,1 repeating, BURST=4 → grants sel=0,1,2,3,0 in order. Each grant gives 4 y_valid pulses on that bit, one IDLE cycle between grants, y_data follows in_data one cycle late.
2. ch_en=4'b1010, all ready → grants alternate sel=1,3,1,3. y_valid[0] and y_valid[2] never assert.
3. Granted sel=2, after 2 beats ch_ready[2]=0 for 5 cycles → in_ready=0, beat_cnt holds 2, no y_valid. After release, exactly 2 more beats, then grant moves to sel=3.
4. Granted sel=1, after 1 beat ch_en[1] deasserts → returns to IDLE next cycle with beat_cnt=0. The next grant goes to channel 2, not 1.
5. in_valid=0 with all channels eligible for 10 cycles → stays IDLE, busy=0, y_valid=0. Setting in_valid=1 produces the first grant 1 cycle later.
6. Assert rst_n=0 during beat 3 of a burst on sel=3 → same cycle y_valid=0, busy=0, sel=0. After release, the first grant is channel 0.
